// File: rtl/axi_lite_reg_splitter_if.sv
// axi_lite_reg_splitter_if: flattened AXI4-Lite bundle of N lanes, lane i at slice i
interface axi_lite_reg_splitter_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N*AW-1:0]   awaddr;
  logic [N*3-1:0]    awprot;
  logic [N-1:0]      awvalid, awready;
  logic [N*DW-1:0]   wdata;
  logic [N*DW/8-1:0] wstrb;
  logic [N-1:0]      wvalid, wready;
  logic [N*2-1:0]    bresp;
  logic [N-1:0]      bvalid, bready;
  logic [N*AW-1:0]   araddr;
  logic [N*3-1:0]    arprot;
  logic [N-1:0]      arvalid, arready;
  logic [N*DW-1:0]   rdata;
  logic [N*2-1:0]    rresp;
  logic [N-1:0]      rvalid, rready;
  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );
  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_reg_splitter.sv
// axi_lite_reg_splitter: 1-to-N AXI4-Lite window decoder, one outstanding transaction, timeout and drain
module axi_lite_reg_splitter #(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    WIN_BITS       = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input logic                     axi_aclk,
  input logic                     axi_aresetn,
  axi_lite_reg_splitter_if.slave  s_axi,
  axi_lite_reg_splitter_if.master m_axi
);
  localparam int N  = NUM_SLAVES;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [AW-1:0] WIN_MASK = ~({AW{1'b1}} << WIN_BITS);
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP} state_t;
  state_t state, state_nx;

  logic          prefer_wr, aw_pend, w_pend, ar_pend, bvalid_q, rvalid_q;
  logic [IW-1:0] idx, idx_dec;
  logic [AW-1:0] addr_q, req_addr, off, win;
  logic [2:0]    prot_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [SW-1:0] strb_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [N-1:0]  stale, sel;
  logic [CW-1:0] cnt;
  logic          wr_elig, rd_elig, grant_wr, grant_rd, accept, mapped, blocked;
  logic          issuing, b_hs, r_hs, tmo;

  assign wr_elig  = s_axi.awvalid[0] & s_axi.wvalid[0];
  assign rd_elig  = s_axi.arvalid[0];
  assign grant_wr = state == IDLE && wr_elig && (prefer_wr || !rd_elig);
  assign grant_rd = state == IDLE && rd_elig && !grant_wr;
  assign accept   = grant_wr | grant_rd;
  assign req_addr = grant_wr ? s_axi.awaddr : s_axi.araddr;
  assign off      = req_addr - BASE_ADDR;
  assign win      = off >> WIN_BITS;
  assign mapped   = req_addr >= BASE_ADDR && win < AW'(N);
  assign idx_dec  = win[IW-1:0];
  // a stale target is refused exactly like an unmapped one, only the response code differs
  assign blocked  = !mapped || stale[idx_dec];
  assign sel      = N'(1) << idx;
  assign issuing  = state == WR_ISSUE || state == RD_ISSUE;
  assign b_hs     = state == WR_ISSUE && !aw_pend && !w_pend && m_axi.bvalid[idx];
  assign r_hs     = state == RD_ISSUE && !ar_pend && m_axi.rvalid[idx];
  assign tmo      = TIMEOUT_CYCLES != 0 && issuing && !b_hs && !r_hs && int'(cnt) + 1 == TIMEOUT_CYCLES;

  assign s_axi.awready = grant_wr;
  assign s_axi.wready  = grant_wr;
  assign s_axi.arready = grant_rd;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign m_axi.awaddr  = {N{addr_q}};
  assign m_axi.araddr  = {N{addr_q}};
  assign m_axi.awprot  = {N{prot_q}};
  assign m_axi.arprot  = {N{prot_q}};
  assign m_axi.wdata   = {N{wdata_q}};
  assign m_axi.wstrb   = {N{strb_q}};
  assign m_axi.awvalid = aw_pend ? sel : '0;
  assign m_axi.wvalid  = w_pend ? sel : '0;
  assign m_axi.arvalid = ar_pend ? sel : '0;
  // stale slaves keep both response readies high so a late beat is swallowed
  assign m_axi.bready  = stale | (state == WR_ISSUE && !aw_pend && !w_pend ? sel : '0);
  assign m_axi.rready  = stale | (state == RD_ISSUE && !ar_pend ? sel : '0);

  // state register
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) state <= IDLE;
    else state <= state_nx;

  // next-state: refused requests skip the issue phase and answer the cycle after accept
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = grant_wr ? (blocked ? WR_RESP : WR_ISSUE) :
                           grant_rd ? (blocked ? RD_RESP : RD_ISSUE) : IDLE;
      WR_ISSUE: state_nx = b_hs || tmo ? WR_RESP : WR_ISSUE;
      WR_RESP:  state_nx = s_axi.bready[0] ? IDLE : WR_RESP;
      RD_ISSUE: state_nx = r_hs || tmo ? RD_RESP : RD_ISSUE;
      RD_RESP:  state_nx = s_axi.rready[0] ? IDLE : RD_RESP;
      default:  state_nx = IDLE;
    endcase
  end

  // request capture, downstream handshakes, response registers, timeout and stale tracking
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      prefer_wr <= 1'b1;
      {aw_pend, w_pend, ar_pend, bvalid_q, rvalid_q} <= '0;
      {idx, addr_q, prot_q, wdata_q, strb_q} <= '0;
      {bresp_q, rresp_q, rdata_q} <= '0;
      stale <= '0;
      cnt <= '0;
    end else begin
      stale <= (stale & ~(m_axi.bvalid | m_axi.rvalid)) | (tmo ? sel : '0);
      cnt <= accept ? '0 : issuing ? cnt + 1'b1 : cnt;
      if (accept) begin
        prefer_wr <= grant_rd;
        idx       <= idx_dec;
        addr_q    <= req_addr & WIN_MASK;
        prot_q    <= grant_wr ? s_axi.awprot : s_axi.arprot;
        wdata_q   <= s_axi.wdata;
        strb_q    <= s_axi.wstrb;
        aw_pend   <= grant_wr && !blocked;
        w_pend    <= grant_wr && !blocked;
        ar_pend   <= grant_rd && !blocked;
        bvalid_q  <= grant_wr && blocked;
        rvalid_q  <= grant_rd && blocked;
        bresp_q   <= mapped ? SLVERR : DECERR;
        rresp_q   <= mapped ? SLVERR : DECERR;
        rdata_q   <= '0;
      end
      if (state == WR_ISSUE) begin
        aw_pend <= aw_pend && !m_axi.awready[idx] && !tmo;
        w_pend  <= w_pend && !m_axi.wready[idx] && !tmo;
        if (b_hs || tmo) begin
          bvalid_q <= 1'b1;
          bresp_q  <= b_hs ? m_axi.bresp[idx*2 +: 2] : SLVERR;
        end
      end
      if (state == RD_ISSUE) begin
        ar_pend <= ar_pend && !m_axi.arready[idx] && !tmo;
        if (r_hs || tmo) begin
          rvalid_q <= 1'b1;
          rresp_q  <= r_hs ? m_axi.rresp[idx*2 +: 2] : SLVERR;
          rdata_q  <= r_hs ? m_axi.rdata[idx*DW +: DW] : '0;
        end
      end
      if (state == WR_RESP && s_axi.bready[0]) bvalid_q <= 1'b0;
      if (state == RD_RESP && s_axi.rready[0]) rvalid_q <= 1'b0;
    end
endmodule

// File: tb/tb_axi_lite_reg_splitter.sv
// tb_axi_lite_reg_splitter: directed checks of decode, arbitration, timeout, drain and async reset
module tb_axi_lite_reg_splitter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // cycle index used to measure latencies
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_reg_splitter_if #(.N(1), .AW(32), .DW(32)) s ();
  axi_lite_reg_splitter_if #(.N(4), .AW(32), .DW(32)) m ();

  axi_lite_reg_splitter #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .s_axi(s), .m_axi(m)
  );

  logic [3:0]  mute = '0;
  logic [3:0]  late_b = '0;
  logic [3:0]  got_aw, got_w, got_ar, bv, rv, ga, gw, gr, vseen;
  logic        clr_seen = 1'b0;
  logic [31:0] rdat [4];
  int          lat [4];
  int          bcnt [4];
  int          rcnt [4];
  logic [31:0] cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  assign m.awready = '1;
  assign m.wready  = '1;
  assign m.arready = '1;
  assign m.bvalid  = bv;
  assign m.rvalid  = rv;
  assign m.bresp   = '0;
  assign m.rresp   = '0;
  assign m.rdata   = {rdat[3], rdat[2], rdat[1], rdat[0]};
  assign ga = ~mute & (got_aw | m.awvalid);
  assign gw = ~mute & (got_w | m.wvalid);
  assign gr = ~mute & (got_ar | m.arvalid);

  // slave models: always ready, respond lat[i] cycles after the request, muted slaves ignore requests
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      got_aw <= '0; got_w <= '0; got_ar <= '0; bv <= '0; rv <= '0;
      for (int i = 0; i < 4; i++) begin bcnt[i] <= 0; rcnt[i] <= 0; end
    end else
      for (int i = 0; i < 4; i++) begin
        if (bv[i] && m.bready[i]) bv[i] <= 1'b0;
        if (rv[i] && m.rready[i]) rv[i] <= 1'b0;
        if (late_b[i]) bv[i] <= 1'b1;
        if (ga[i] && gw[i] && bcnt[i] == lat[i]) begin
          bv[i] <= 1'b1; got_aw[i] <= 1'b0; got_w[i] <= 1'b0; bcnt[i] <= 0;
        end else begin
          got_aw[i] <= ga[i]; got_w[i] <= gw[i]; bcnt[i] <= ga[i] && gw[i] ? bcnt[i] + 1 : 0;
        end
        if (gr[i] && rcnt[i] == lat[i]) begin
          rv[i] <= 1'b1; got_ar[i] <= 1'b0; rcnt[i] <= 0;
        end else begin
          got_ar[i] <= gr[i]; rcnt[i] <= gr[i] ? rcnt[i] + 1 : 0;
        end
      end

  // sticky record of which slaves saw any request valid
  always @(posedge clk) vseen <= clr_seen ? '0 : vseen | m.awvalid | m.wvalid | m.arvalid;

  // capture what slave 1 was handed on its write channels
  always @(negedge clk)
    if (m.awvalid[1]) begin
      cap_awaddr <= m.awaddr[63:32];
      cap_wdata  <= m.wdata[63:32];
      cap_wstrb  <= m.wstrb[7:4];
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_seen();
    @(negedge clk); clr_seen = 1'b1;
    @(negedge clk); clr_seen = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                    output logic [1:0] resp, output int lt);
    int n, t0;
    @(negedge clk);
    s.awaddr = a; s.awprot = 3'b010; s.wdata = d; s.wstrb = st;
    s.awvalid = 1'b1; s.wvalid = 1'b1; s.bready = 1'b1;
    n = 0;
    #1;
    while (!s.awready && n < 100) begin @(negedge clk); #1; n++; end
    chk("wr_accept", n < 100, 1);
    t0 = cyc;
    @(posedge clk); #1;
    s.awvalid = 1'b0; s.wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s.bvalid && n < 100);
    chk("wr_resp_seen", s.bvalid, 1);
    resp = s.bresp;
    lt = cyc - t0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input int hold,
                    output logic [31:0] d, output logic [1:0] resp, output int lt);
    int n, t0;
    @(negedge clk);
    s.araddr = a; s.arprot = 3'b001; s.arvalid = 1'b1; s.rready = hold == 0;
    n = 0;
    #1;
    while (!s.arready && n < 100) begin @(negedge clk); #1; n++; end
    chk("rd_accept", n < 100, 1);
    t0 = cyc;
    @(posedge clk); #1;
    s.arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s.rvalid && n < 100);
    chk("rd_resp_seen", s.rvalid, 1);
    d = s.rdata;
    resp = s.rresp;
    lt = cyc - t0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("rd_hold_stable", {s.rvalid, s.rresp, s.rdata}, {1'b1, resp, d});
    end
    s.rready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [3:0]  g;
    int          lt, n, k;
    s.awaddr = '0; s.awprot = '0; s.awvalid = 1'b0;
    s.wdata = '0; s.wstrb = '0; s.wvalid = 1'b0; s.bready = 1'b1;
    s.araddr = '0; s.arprot = '0; s.arvalid = 1'b0; s.rready = 1'b1;
    lat  = '{0, 0, 0, 0};
    rdat = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'h1234_5678};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_upstream", {s.bvalid, s.rvalid, s.bresp, s.rresp, s.rdata, s.awready, s.arready}, 0);
    chk("rst_m_valid", {m.awvalid, m.wvalid, m.arvalid}, 0);
    chk("rst_m_ready", {m.bready, m.rready}, 0);
    rst_n = 1'b1;

    // write and read presented together: write first after reset, then alternate
    @(negedge clk);
    s.awaddr = 32'h4000_0010; s.wdata = 32'h0000_0001; s.wstrb = 4'hF; s.araddr = 32'h4000_1020;
    s.awvalid = 1'b1; s.wvalid = 1'b1; s.arvalid = 1'b1;
    g = '0; n = 0; k = 0;
    #1;
    while (k < 4 && n < 200) begin
      if (s.awready) begin g[3-k] = 1'b1; k++; end
      else if (s.arready) begin g[3-k] = 1'b0; k++; end
      if (k < 4) begin @(negedge clk); #1; n++; end
    end
    @(posedge clk); #1;
    s.awvalid = 1'b0; s.wvalid = 1'b0; s.arvalid = 1'b0;
    chk("grant_count", k, 4);
    chk("grant_order_wrwr", g, 4'b1010);
    repeat (8) @(negedge clk);

    // address without data is never accepted
    @(negedge clk);
    s.awaddr = 32'h4000_0000; s.awvalid = 1'b1; s.wvalid = 1'b0;
    n = 0;
    repeat (10) begin #1; if (s.awready || s.wready) n++; @(negedge clk); end
    s.awvalid = 1'b0;
    chk("aw_without_w", n, 0);

    // zero-wait write to slave 1: accept 0, s_bvalid at 3
    clear_seen();
    wr(32'h4000_1008, 32'hDEAD_BEEF, 4'hF, resp, lt);
    chk("wr1_resp", resp, 2'b00);
    chk("wr1_lat", lt, 3);
    chk("wr1_awaddr", cap_awaddr, 32'h0000_0008);
    chk("wr1_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("wr1_wstrb", cap_wstrb, 4'hF);
    chk("wr1_only_s1", vseen, 4'b0010);

    // slave 3 read with 5 wait cycles, upstream holds rready low for 3 cycles
    lat[3] = 5;
    clear_seen();
    rd(32'h4000_3010, 3, d, resp, lt);
    chk("rd3_data", d, 32'h1234_5678);
    chk("rd3_resp", resp, 2'b00);
    chk("rd3_lat", lt, 8);
    chk("rd3_only_s3", vseen, 4'b1000);

    // unmapped below base and above last window
    clear_seen();
    rd(32'h3FFF_FFFC, 0, d, resp, lt);
    chk("unmap_lo_resp", resp, 2'b11);
    chk("unmap_lo_data", d, 0);
    chk("unmap_lo_lat", lt, 1);
    rd(32'h4000_4000, 0, d, resp, lt);
    chk("unmap_hi_resp", resp, 2'b11);
    chk("unmap_hi_data", d, 0);
    chk("unmap_no_valid", vseen, 4'b0000);

    // slave 2 never answers: issue at cycle 1, SLVERR visible 16 cycles later
    mute[2] = 1'b1;
    clear_seen();
    wr(32'h4000_2000, 32'h5555_AAAA, 4'h3, resp, lt);
    chk("tmo_resp", resp, 2'b10);
    chk("tmo_lat", lt, 17);
    chk("tmo_dropped", {m.awvalid, m.wvalid}, 0);
    chk("stale_drain_ready", {m.bready[2], m.rready[2]}, 2'b11);

    // access to the stale slave is refused without issue
    clear_seen();
    rd(32'h4000_2004, 0, d, resp, lt);
    chk("stale_resp", resp, 2'b10);
    chk("stale_data", d, 0);
    chk("stale_lat", lt, 1);
    chk("stale_no_issue", vseen, 4'b0000);

    // late beat is drained and never reaches upstream
    @(negedge clk); late_b = 4'b0100;
    @(posedge clk); #1; late_b = '0;
    n = 0;
    repeat (4) begin @(negedge clk); if (s.bvalid || s.rvalid) n++; end
    chk("late_not_forwarded", n, 0);
    chk("stale_cleared", {m.bready[2], m.rready[2]}, 2'b00);
    mute[2] = 1'b0;
    wr(32'h4000_2010, 32'h0BAD_F00D, 4'hF, resp, lt);
    chk("s2_recovered_resp", resp, 2'b00);
    chk("s2_recovered_lat", lt, 3);

    // asynchronous reset while a read is being issued
    mute[0] = 1'b1;
    @(negedge clk);
    s.araddr = 32'h4000_0004; s.arvalid = 1'b1;
    n = 0;
    #1;
    while (!s.arready && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    s.arvalid = 1'b0;
    @(negedge clk);
    chk("rst_pre_arvalid", m.arvalid, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valids", {m.arvalid, m.rready, m.bready, s.rvalid, s.bvalid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mute[0] = 1'b0;
    rd(32'h4000_0004, 0, d, resp, lt);
    chk("post_rst_data", d, 32'hA0A0_0000);
    chk("post_rst_resp", resp, 2'b00);
    chk("post_rst_lat", lt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
